tt_vpu_ovi_sb_monitor: RTL and testbench
========================================

TT_VPU_OVI_SB_MONITOR -- requirements
Module: tt_vpu_ovi_sb_monitor

Interface
REQ-001 SHALL have parameter SB_ENTRIES, default 32, number of scoreboard ids tracked (power of two, 2..64).
REQ-002 SHALL have parameter SB_ID_W, default $clog2(SB_ENTRIES), sb_id width.
REQ-003 SHALL have parameter MAX_CREDITS, default 16, credit counter ceiling.
REQ-004 SHALL have parameter TIMEOUT, default 4096, age limit in cycles; used only under REQ-030.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports issue_valid input 1, issue_sb_id input SB_ID_W, issue_credit input 1: OVI issue bus and credit return.
REQ-008 SHALL have ports dispatch_sb_id input SB_ID_W, dispatch_next_senior input 1, dispatch_kill input 1: OVI dispatch bus.
REQ-009 SHALL have ports completed_valid input 1, completed_sb_id input SB_ID_W: OVI completion bus.
REQ-010 SHALL have outputs err_valid 1 (one-cycle error pulse), err_code 4 (code of reported error), err_sb_id SB_ID_W (offending id), err_sticky 8 (bit n-1 set once code n seen).
REQ-011 SHALL have outputs sb_busy SB_ENTRIES (entry not FREE), outstanding_cnt SB_ID_W+1 (count of non-FREE entries), credit_cnt $clog2(MAX_CREDITS+1) (available issue credits).

Function
REQ-012 SHALL keep a 2-bit state per entry: FREE, ISSUED, SENIOR.
REQ-013 Legal transitions SHALL be: FREE->ISSUED on issue; ISSUED->SENIOR on next_senior; ISSUED->FREE on kill; SENIOR->FREE on completed_valid.
REQ-014 Issue and dispatch of the same id in the same cycle SHALL be legal: FREE->SENIOR (next_senior) or FREE->FREE (kill).
REQ-015 Error codes SHALL be: 1 issue to non-FREE id; 2 dispatch to id neither ISSUED nor same-cycle issued; 3 next_senior and kill both high; 4 completion to non-SENIOR id; 5 completed_sb_id equals a valid issue_sb_id or dispatch_sb_id same cycle; 6 issue with credit_cnt==0 and no same-cycle credit; 7 credit return at credit_cnt==MAX_CREDITS; 8 timeout.
REQ-016 A dispatch event SHALL be next_senior OR kill high; dispatch_sb_id is ignored otherwise.
REQ-017 An offending event SHALL NOT change entry state or counters; non-offending events in the same cycle SHALL apply normally.
REQ-018 Under code 3, neither senior nor kill SHALL apply; under code 5, the completion SHALL be dropped and issue/dispatch applied.
REQ-019 Multiple errors in one cycle SHALL report the lowest code in err_code/err_sb_id; all SHALL set err_sticky bits.
REQ-020 err_valid, err_code, err_sb_id SHALL be registered, asserted the cycle after the event, held only one cycle; err_code/err_sb_id hold last value when err_valid low.
REQ-021 sb_busy, outstanding_cnt SHALL reflect state one cycle after the event (registered).
REQ-022 credit_cnt SHALL be +1 on issue_credit, -1 on accepted issue, unchanged when both; saturates at 0 and MAX_CREDITS (codes 6/7 flag violation).
REQ-023 outstanding_cnt SHALL equal popcount(sb_busy) at all times; max value SB_ENTRIES without wrap.
REQ-024 err_sticky SHALL clear only on reset.

Reset
REQ-025 On reset assertion all entries SHALL go FREE immediately, regardless of clock.
REQ-026 Reset values SHALL be: err_valid 0, err_code 0, err_sb_id 0, err_sticky 0, sb_busy 0, outstanding_cnt 0, credit_cnt 0.
REQ-027 Inputs SHALL be ignored while reset high; first event sampled on first rising clk after deassertion.
REQ-028 Reset mid-operation SHALL discard all in-flight state with no error reported.

Configuration
REQ-029 Macro TT_VPU_OVI_SB_MONITOR_TIMEOUT_EN SHALL select the age-timeout feature.
REQ-030 With macro: per-entry age counter cleared on leaving FREE, increments each cycle while non-FREE, code 8 raised once when it reaches TIMEOUT; entry state unchanged.
REQ-031 Without macro: no age counters; code 8 never produced; err_sticky[7] tied 0.

Verification
REQ-032 Reset, 4 credits, issue id 3, next_senior id 3, complete id 3 -> sb_busy[3] 1 then 0, outstanding 1->0, credit_cnt 4->3, no errors.
REQ-033 Issue id 5 twice with no completion -> err_valid one cycle after second issue, err_code 1, err_sb_id 5, err_sticky 0x01.
REQ-034 Issue id 2 while completing id 2 same cycle -> err_code 5, id 2 ends ISSUED, outstanding_cnt unchanged by completion.
REQ-035 credit_cnt 0, issue id 1 -> err_code 6, sb_busy[1] stays 0; MAX_CREDITS+1 credit returns -> err_code 7, credit_cnt 16.
REQ-036 Same cycle: next_senior+kill on id 4 and completion to FREE id 9 -> err_code 3 reported, err_sticky 0x0C.
REQ-037 With macro, TIMEOUT 8, issue id 7 never completed -> single err_code 8, err_sb_id 7, 8 cycles after issue; without macro no error.

Source files
------------

// File: rtl/tt_vpu_ovi_sb_monitor.sv
// OVI scoreboard protocol monitor: tracks per-id FREE/ISSUED/SENIOR state and issue credits, flags protocol errors.
// Optional age timeout (error code 8) enabled by defining TT_VPU_OVI_SB_MONITOR_TIMEOUT_EN.
module tt_vpu_ovi_sb_monitor #(
   parameter int SB_ENTRIES  = 32,
   parameter int SB_ID_W     = $clog2(SB_ENTRIES),
   parameter int MAX_CREDITS = 16,
   parameter int TIMEOUT     = 4096,
   localparam int CREDIT_W   = $clog2(MAX_CREDITS + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  issue_valid,
   input  logic [SB_ID_W-1:0]    issue_sb_id,
   input  logic                  issue_credit,
   input  logic [SB_ID_W-1:0]    dispatch_sb_id,
   input  logic                  dispatch_next_senior,
   input  logic                  dispatch_kill,
   input  logic                  completed_valid,
   input  logic [SB_ID_W-1:0]    completed_sb_id,
   output logic                  err_valid,
   output logic [3:0]            err_code,
   output logic [SB_ID_W-1:0]    err_sb_id,
   output logic [7:0]            err_sticky,
   output logic [SB_ENTRIES-1:0] sb_busy,
   output logic [SB_ID_W:0]      outstanding_cnt,
   output logic [CREDIT_W-1:0]   credit_cnt
);

   localparam logic [1:0] ST_FREE   = 2'd0;
   localparam logic [1:0] ST_ISSUED = 2'd1;
   localparam logic [1:0] ST_SENIOR = 2'd2;

   logic [1:0]            sb_state  [SB_ENTRIES];
   logic [1:0]            state_nxt [SB_ENTRIES];
   logic [SB_ID_W:0]      busy_cnt_nxt;
   logic [CREDIT_W-1:0]   credit_nxt;

   logic                  disp_ev;
   logic                  e1, e2, e3, e4, e5, e6, e7;
   logic                  issue_acc, disp_acc, comp_acc, credit_acc;
   logic                  to_hit;
   logic [SB_ID_W-1:0]    to_id;
   logic [7:0]            err_vec;
   logic [3:0]            code_nxt;
   logic [SB_ID_W-1:0]    id_nxt;

   // Error classification; a completion that collides with issue/dispatch is dropped
   // before its own state check, so code 5 masks code 4 for that completion.
   assign disp_ev    = dispatch_next_senior | dispatch_kill;
   assign e1         = issue_valid && (sb_state[issue_sb_id] != ST_FREE);
   assign e6         = issue_valid && (credit_cnt == '0) && !issue_credit;
   assign issue_acc  = issue_valid && !e1 && !e6;
   assign e2         = disp_ev && !((sb_state[dispatch_sb_id] == ST_ISSUED) ||
                                    (issue_acc && (issue_sb_id == dispatch_sb_id)));
   assign e3         = dispatch_next_senior && dispatch_kill;
   assign disp_acc   = disp_ev && !e2 && !e3;
   assign e5         = completed_valid &&
                       ((issue_valid && (completed_sb_id == issue_sb_id)) ||
                        (disp_ev && (completed_sb_id == dispatch_sb_id)));
   assign e4         = completed_valid && !e5 && (sb_state[completed_sb_id] != ST_SENIOR);
   assign comp_acc   = completed_valid && !e4 && !e5;
   assign e7         = issue_credit && (credit_cnt == CREDIT_W'(MAX_CREDITS)) && !issue_acc;
   assign credit_acc = issue_credit && !e7;

   assign err_vec = {to_hit, e7, e6, e5, e4, e3, e2, e1};

   always_comb begin
      busy_cnt_nxt = '0;
      for (int i = 0; i < SB_ENTRIES; i++) begin
         state_nxt[i] = sb_state[i];
         if (issue_acc && (issue_sb_id == SB_ID_W'(i)))
            state_nxt[i] = ST_ISSUED;
         if (disp_acc && (dispatch_sb_id == SB_ID_W'(i)))
            state_nxt[i] = dispatch_next_senior ? ST_SENIOR : ST_FREE;
         if (comp_acc && (completed_sb_id == SB_ID_W'(i)))
            state_nxt[i] = ST_FREE;
         busy_cnt_nxt = busy_cnt_nxt + (SB_ID_W + 1)'(state_nxt[i] != ST_FREE);
      end
   end

   always_comb begin
      for (int i = 0; i < SB_ENTRIES; i++)
         sb_busy[i] = (sb_state[i] != ST_FREE);
   end

   always_comb begin
      credit_nxt = credit_cnt;
      case ({credit_acc, issue_acc})
         2'b10:   credit_nxt = credit_cnt + CREDIT_W'(1);
         2'b01:   credit_nxt = credit_cnt - CREDIT_W'(1);
         default: credit_nxt = credit_cnt;
      endcase
   end

   // Lowest active code wins the report; credit overflow has no associated id.
   always_comb begin
      code_nxt = 4'd0;
      id_nxt   = '0;
      if (e1)          begin code_nxt = 4'd1; id_nxt = issue_sb_id;     end
      else if (e2)     begin code_nxt = 4'd2; id_nxt = dispatch_sb_id;  end
      else if (e3)     begin code_nxt = 4'd3; id_nxt = dispatch_sb_id;  end
      else if (e4)     begin code_nxt = 4'd4; id_nxt = completed_sb_id; end
      else if (e5)     begin code_nxt = 4'd5; id_nxt = completed_sb_id; end
      else if (e6)     begin code_nxt = 4'd6; id_nxt = issue_sb_id;     end
      else if (e7)     begin code_nxt = 4'd7; id_nxt = '0;              end
      else if (to_hit) begin code_nxt = 4'd8; id_nxt = to_id;           end
   end

`ifdef TT_VPU_OVI_SB_MONITOR_TIMEOUT_EN
   localparam int AGE_W = $clog2(TIMEOUT + 1);

   logic [AGE_W-1:0] age [SB_ENTRIES];

   // Fires on the cycle the age steps to TIMEOUT; saturation makes it one-shot per residency.
   always_comb begin
      to_hit = 1'b0;
      to_id  = '0;
      for (int i = SB_ENTRIES - 1; i >= 0; i--) begin
         if ((sb_state[i] != ST_FREE) && (age[i] == AGE_W'(TIMEOUT - 1))) begin
            to_hit = 1'b1;
            to_id  = SB_ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SB_ENTRIES; i++)
            age[i] <= '0;
      end else begin
         for (int i = 0; i < SB_ENTRIES; i++) begin
            if (sb_state[i] == ST_FREE)
               age[i] <= '0;
            else if (age[i] != AGE_W'(TIMEOUT))
               age[i] <= age[i] + AGE_W'(1);
         end
      end
   end
`else
   assign to_hit = 1'b0;
   assign to_id  = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SB_ENTRIES; i++)
            sb_state[i] <= ST_FREE;
         outstanding_cnt <= '0;
         credit_cnt      <= '0;
         err_valid       <= 1'b0;
         err_code        <= 4'd0;
         err_sb_id       <= '0;
         err_sticky      <= 8'h00;
      end else begin
         for (int i = 0; i < SB_ENTRIES; i++)
            sb_state[i] <= state_nxt[i];
         outstanding_cnt <= busy_cnt_nxt;
         credit_cnt      <= credit_nxt;
         err_valid       <= |err_vec;
         err_sticky      <= err_sticky | err_vec;
         if (|err_vec) begin
            err_code  <= code_nxt;
            err_sb_id <= id_nxt;
         end
      end
   end

endmodule

// File: tb/tb_tt_vpu_ovi_sb_monitor.sv
// Directed table-driven bench for tt_vpu_ovi_sb_monitor, plus credit-saturation and age-timeout sequences.
module tb_tt_vpu_ovi_sb_monitor;

   localparam int SB_ENTRIES  = 32;
   localparam int SB_ID_W     = 5;
   localparam int MAX_CREDITS = 16;
   localparam int TIMEOUT     = 8;
   localparam int NVEC        = 26;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  issue_valid = 1'b0;
   logic [SB_ID_W-1:0]    issue_sb_id = '0;
   logic                  issue_credit = 1'b0;
   logic [SB_ID_W-1:0]    dispatch_sb_id = '0;
   logic                  dispatch_next_senior = 1'b0;
   logic                  dispatch_kill = 1'b0;
   logic                  completed_valid = 1'b0;
   logic [SB_ID_W-1:0]    completed_sb_id = '0;
   logic                  err_valid;
   logic [3:0]            err_code;
   logic [SB_ID_W-1:0]    err_sb_id;
   logic [7:0]            err_sticky;
   logic [SB_ENTRIES-1:0] sb_busy;
   logic [SB_ID_W:0]      outstanding_cnt;
   logic [4:0]            credit_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic        rst;
      logic        iv;
      logic [4:0]  iid;
      logic        ic;
      logic [4:0]  did;
      logic        ns;
      logic        k;
      logic        cv;
      logic [4:0]  cid;
      logic [31:0] e_busy;
      logic [5:0]  e_out;
      logic [4:0]  e_cr;
      logic        e_ev;
      logic [3:0]  e_code;
      logic [4:0]  e_id;
      logic [7:0]  e_sticky;
   } vec_t;

   vec_t vecs [NVEC];

   always #5 clk = ~clk;

   tt_vpu_ovi_sb_monitor #(
      .SB_ENTRIES  (SB_ENTRIES),
      .SB_ID_W     (SB_ID_W),
      .MAX_CREDITS (MAX_CREDITS),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .issue_valid          (issue_valid),
      .issue_sb_id          (issue_sb_id),
      .issue_credit         (issue_credit),
      .dispatch_sb_id       (dispatch_sb_id),
      .dispatch_next_senior (dispatch_next_senior),
      .dispatch_kill        (dispatch_kill),
      .completed_valid      (completed_valid),
      .completed_sb_id      (completed_sb_id),
      .err_valid            (err_valid),
      .err_code             (err_code),
      .err_sb_id            (err_sb_id),
      .err_sticky           (err_sticky),
      .sb_busy              (sb_busy),
      .outstanding_cnt      (outstanding_cnt),
      .credit_cnt           (credit_cnt)
   );

   task automatic check_value(input string name, input int step,
                              input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, step, actual, expected);
      end
   endtask

   task automatic drive_idle();
      issue_valid          = 1'b0;
      issue_sb_id          = '0;
      issue_credit         = 1'b0;
      dispatch_sb_id       = '0;
      dispatch_next_senior = 1'b0;
      dispatch_kill        = 1'b0;
      completed_valid      = 1'b0;
      completed_sb_id      = '0;
   endtask

   task automatic drive_vec(input vec_t v);
      issue_valid          = v.iv;
      issue_sb_id          = v.iid;
      issue_credit         = v.ic;
      dispatch_sb_id       = v.did;
      dispatch_next_senior = v.ns;
      dispatch_kill        = v.k;
      completed_valid      = v.cv;
      completed_sb_id      = v.cid;
   endtask

   // Reset rows assert reset between edges with busy inputs to show it is asynchronous and masks inputs.
   task automatic apply_vector(input int step, input vec_t v);
      @(negedge clk);
      if (v.rst) begin
         reset                = 1'b1;
         issue_valid          = 1'b1;
         issue_sb_id          = 5'd9;
         issue_credit         = 1'b1;
         dispatch_sb_id       = 5'd9;
         dispatch_next_senior = 1'b1;
         completed_valid      = 1'b1;
         completed_sb_id      = 5'd3;
         #2;
         check_value("async_reset_busy", step, 32'(sb_busy), 32'h0);
         @(posedge clk);
         #1;
         drive_idle();
         reset = 1'b0;
      end else begin
         drive_vec(v);
         @(posedge clk);
         #1;
      end
      check_value("sb_busy",         step, 32'(sb_busy),         v.e_busy);
      check_value("outstanding_cnt", step, 32'(outstanding_cnt), 32'(v.e_out));
      check_value("credit_cnt",      step, 32'(credit_cnt),      32'(v.e_cr));
      check_value("err_valid",       step, 32'(err_valid),       32'(v.e_ev));
      check_value("err_code",        step, 32'(err_code),        32'(v.e_code));
      check_value("err_sb_id",       step, 32'(err_sb_id),       32'(v.e_id));
      check_value("err_sticky",      step, 32'(err_sticky),      32'(v.e_sticky));
   endtask

   initial begin
      vec_t v;
      int   pulses;
      int   pulse_cycle;
      logic [3:0] pulse_code;
      logic [4:0] pulse_id;

      //            rst iv iid ic did ns k cv cid  busy      out cr ev code id sticky
      vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 8'h00};
      vecs[1]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0,    0, 1, 0, 0, 0, 8'h00};
      vecs[2]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0,    0, 2, 0, 0, 0, 8'h00};
      vecs[3]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0,    0, 3, 0, 0, 0, 8'h00};
      vecs[4]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0,    0, 4, 0, 0, 0, 8'h00};
      vecs[5]  = '{0, 1, 3, 0, 0, 0, 0, 0, 0, 32'h8,    1, 3, 0, 0, 0, 8'h00};
      vecs[6]  = '{0, 0, 0, 0, 3, 1, 0, 0, 0, 32'h8,    1, 3, 0, 0, 0, 8'h00};
      vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h0,    0, 3, 0, 0, 0, 8'h00};
      vecs[8]  = '{0, 1, 5, 0, 0, 0, 0, 0, 0, 32'h20,   1, 2, 0, 0, 0, 8'h00};
      vecs[9]  = '{0, 1, 5, 0, 0, 0, 0, 0, 0, 32'h20,   1, 2, 1, 1, 5, 8'h01};
      vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20,   1, 2, 0, 1, 5, 8'h01};
      vecs[11] = '{0, 0, 0, 0, 5, 1, 0, 0, 0, 32'h20,   1, 2, 0, 1, 5, 8'h01};
      vecs[12] = '{0, 1, 2, 0, 0, 0, 0, 1, 2, 32'h24,   2, 1, 1, 5, 2, 8'h11};
      vecs[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 8'h00};
      vecs[14] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0,    0, 1, 0, 0, 0, 8'h00};
      vecs[15] = '{0, 1, 4, 0, 0, 0, 0, 0, 0, 32'h10,   1, 0, 0, 0, 0, 8'h00};
      vecs[16] = '{0, 0, 0, 0, 4, 1, 1, 1, 9, 32'h10,   1, 0, 1, 3, 4, 8'h0C};
      vecs[17] = '{0, 0, 0, 0, 4, 0, 1, 0, 0, 32'h0,    0, 0, 0, 3, 4, 8'h0C};
      vecs[18] = '{0, 0, 0, 0, 6, 1, 0, 0, 0, 32'h0,    0, 0, 1, 2, 6, 8'h0E};
      vecs[19] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 8'h00};
      vecs[20] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,    0, 0, 1, 6, 1, 8'h20};
      vecs[21] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 32'h2,    1, 0, 0, 6, 1, 8'h20};
      vecs[22] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 32'h0,    0, 0, 0, 6, 1, 8'h20};
      vecs[23] = '{0, 1, 8, 1, 8, 0, 1, 0, 0, 32'h0,    0, 0, 0, 6, 1, 8'h20};
      vecs[24] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 32'h1,    1, 0, 0, 6, 1, 8'h20};
      vecs[25] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,    0, 0, 0, 6, 1, 8'h20};

      for (int i = 0; i < NVEC; i++)
         apply_vector(i, vecs[i]);

      // Credit ceiling: fill from 0 to MAX_CREDITS, then one more return overflows.
      for (int k = 1; k <= MAX_CREDITS + 1; k++) begin
         @(negedge clk);
         drive_idle();
         issue_credit = 1'b1;
         @(posedge clk);
         #1;
         if (k <= MAX_CREDITS) begin
            check_value("credit_fill_cnt", 100 + k, 32'(credit_cnt), 32'(k));
            check_value("credit_fill_err", 100 + k, 32'(err_valid), 32'h0);
         end else begin
            check_value("credit_ovf_valid",  100 + k, 32'(err_valid),  32'h1);
            check_value("credit_ovf_code",   100 + k, 32'(err_code),   32'h7);
            check_value("credit_ovf_cnt",    100 + k, 32'(credit_cnt), 32'(MAX_CREDITS));
            check_value("credit_ovf_sticky", 100 + k, 32'(err_sticky), 32'h60);
         end
      end
      @(negedge clk);
      drive_idle();

      // Age timeout: id 7 issued and left outstanding.
      v = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 8'h00};
      apply_vector(200, v);
      v = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 8'h00};
      apply_vector(201, v);
      v = '{0, 1, 7, 0, 0, 0, 0, 0, 0, 32'h80, 1, 0, 0, 0, 0, 8'h00};
      apply_vector(202, v);
      drive_idle();
      pulses      = 0;
      pulse_cycle = 0;
      pulse_code  = '0;
      pulse_id    = '0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (err_valid) begin
            pulses++;
            if (pulses == 1) begin
               pulse_cycle = n;
               pulse_code  = err_code;
               pulse_id    = err_sb_id;
            end
         end
      end
`ifdef TT_VPU_OVI_SB_MONITOR_TIMEOUT_EN
      check_value("timeout_pulses", 203, 32'(pulses),      32'h1);
      check_value("timeout_cycle",  203, 32'(pulse_cycle), 32'(TIMEOUT));
      check_value("timeout_code",   203, 32'(pulse_code),  32'h8);
      check_value("timeout_id",     203, 32'(pulse_id),    32'h7);
      check_value("timeout_sticky", 203, 32'(err_sticky),  32'h80);
`else
      check_value("no_timeout_pulses", 203, 32'(pulses),     32'h0);
      check_value("no_timeout_sticky", 203, 32'(err_sticky), 32'h00);
`endif
      check_value("timeout_busy_kept", 203, 32'(sb_busy), 32'h80);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
